jk_sync_counter: RTL
====================

Name: jk_sync_counter

Overview:
Synchronous modulo-N up/down counter whose state bits are held in JK flip-flops. It consumes the JK stage: each count bit is one JK cell, driven with J/K values computed from the next-state logic. It provides the team's counter primitive for dividers and sequencers, with a terminal-count output for cascading.

Parameters:
WIDTH, 4, number of count bits (JK cells).
MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration must fail otherwise.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-low (0 = reset asserted).
clr  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value applied when load=1.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
count  output  WIDTH  current count; q of the JK cells.
tc  output  1  terminal count (combinational).
wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset: when rst=0, count=0 and wrap=0 immediately, independent of clk. This holds mid-count. On release, the first rising edge with rst=1 acts normally.
- Per-edge priority: clr > load > en > hold.
- clr=1: count<=0 and wrap<=0, regardless of load and en.
- load=1 (clr=0): count<=load_val. If load_val >= MODULUS, count<=MODULUS-1 (saturate). wrap<=0.
- en=1, up=1: if count==MODULUS-1, then count<=0 and wrap<=1; else count<=count+1 and wrap<=0.
- en=1, up=0: if count==0, then count<=MODULUS-1 and wrap<=1; else count<=count-1 and wrap<=0.
- en=0, clr=0, load=0: count holds and wrap<=0.
- Latency: count updates one edge after the control is sampled. wrap is high for exactly the cycle after the wrapping edge.
- tc = en & (up ? count==MODULUS-1 : count==0). It is purely combinational and is gated by neither clr nor load.
- A direction change while en=1 takes effect on the same edge. There is no pipeline and no extra cycle.
- JK drive per bit i, with nxt = the selected next state:
  - Count/hold path: J=K=count[i]^nxt[i]. Toggle where the bit changes, otherwise J=K=0.
  - clr/load path: J=nxt[i] and K=~nxt[i], i.e. set/reset mode.
  - J=K=1 is used only for toggling. Bits at or above MODULUS are never reachable.
- Arithmetic is WIDTH bits wide, with no carry out. Wrap is determined by MODULUS, not by 2**WIDTH overflow, except when MODULUS=2**WIDTH, where the two coincide.

Decomposition:
- Shared package: JK control encodings (HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11), plus a function that maps (current bit, next bit, force) to {j,k}.
- Sub-module jk_ff_async_rst: a single JK cell with asynchronous active-low rst, q and q_bar outputs, and the same port order as the existing JK cell. It is instantiated WIDTH times by a generate loop.
- The wrap flop and the tc logic live in the top module.

Test Plan:
1. Hold rst=0 for 12 ns with en=1, then release. Expect count=0 while reset is held. Then with up=1 for 12 edges, expect 0..9, 0, 1. Expect wrap=1 only in the cycle after 9->0, and tc=1 while count=9.
2. Reach count=3, then up=0 and en=1 for 5 edges. Expect 2, 1, 0, 9, 8. Expect wrap pulse after 0->9, and tc=1 while count=0.
3. Apply load=1 with load_val=7, then load_val=12. Expect count=7, then count=9 (saturated). Expect en ignored during load and wrap=0.
4. Apply clr=1, load=1, en=1 together at count=5. Expect count=0 and wrap=0. Then apply en=0 for 3 edges and expect count to hold 0.
5. Drive rst=0 mid-cycle (not at an edge) while count=6. Expect count=0 before the next edge. Release, then expect counting to resume from 0.
6. Build with MODULUS=16, WIDTH=4, up=1. Expect 15->0 with a wrap pulse. Check q_bar of every cell equals ~count[i] throughout.

Source files
------------

// File: rtl/jk_sync_counter_pkg.sv
// Shared definitions for the JK-based synchronous counter.
//   jk_ctrl_e : {j,k} control encodings of a JK cell
//   jk_drive  : maps (current bit, next bit, force) to the {j,k} pair
package jk_sync_counter_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_ctrl_e;

   // force_sr selects set/reset mode (clr/load); otherwise toggle only changing bits
   function automatic jk_ctrl_e jk_drive(input logic cur, input logic nxt, input logic force_sr);
      jk_ctrl_e ctrl;
      if (force_sr) begin
         ctrl = nxt ? JK_SET : JK_RESET;
      end else begin
         ctrl = (cur ^ nxt) ? JK_TOGGLE : JK_HOLD;
      end
      return ctrl;
   endfunction

endpackage

// File: rtl/jk_ff_async_rst.sv
// Single JK flip-flop cell with asynchronous active-low reset.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low
//   j, k  : JK controls (00 hold, 01 reset, 10 set, 11 toggle)
//   q     : stored bit
//   q_bar : complement of q
module jk_ff_async_rst
   import jk_sync_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_bar
);

   logic q_d;
   logic q_q;

   // JK next-state
   always_comb begin
      q_d = q_q;
      case (jk_ctrl_e'({j, k}))
         JK_HOLD:   q_d = q_q;
         JK_RESET:  q_d = 1'b0;
         JK_SET:    q_d = 1'b1;
         JK_TOGGLE: q_d = ~q_q;
         default:   q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign q_bar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells.
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-low
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val (saturates at MODULUS-1)
//   load_val : load value
//   en       : count enable
//   up       : 1 = increment, 0 = decrement
//   count    : current count (q of the JK cells)
//   tc       : combinational terminal count
//   wrap     : registered pulse in the cycle after a wrap-around
module jk_sync_counter
   import jk_sync_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
      $error("jk_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic [WIDTH-1:0] count_bar;
   logic [WIDTH-1:0] nxt_c;
   logic [WIDTH-1:0] j_c;
   logic [WIDTH-1:0] k_c;
   logic             force_sr_c;
   logic             is_zero_c;
   logic             is_max_c;
   logic             wrap_d;
   logic             wrap_q;

   assign is_zero_c = &count_bar;
   assign is_max_c  = (count == MAX_CNT);

   // Next count selection (clr > load > en > hold) and per-bit JK drive
   always_comb begin
      nxt_c      = count;
      force_sr_c = 1'b0;
      wrap_d     = 1'b0;
      j_c        = '0;
      k_c        = '0;
      if (clr) begin
         nxt_c      = '0;
         force_sr_c = 1'b1;
      end else if (load) begin
         force_sr_c = 1'b1;
         nxt_c      = (32'(load_val) >= MODULUS) ? MAX_CNT : load_val;
      end else if (en) begin
         if (up) begin
            if (is_max_c) begin
               nxt_c  = '0;
               wrap_d = 1'b1;
            end else begin
               nxt_c = count + WIDTH'(1);
            end
         end else begin
            if (is_zero_c) begin
               nxt_c  = MAX_CNT;
               wrap_d = 1'b1;
            end else begin
               nxt_c = count - WIDTH'(1);
            end
         end
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
         {j_c[i], k_c[i]} = jk_drive(count[i], nxt_c[i], force_sr_c);
      end
   end

   for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
      jk_ff_async_rst u_jk (
         .clk   (clk),
         .rst   (rst),
         .j     (j_c[g]),
         .k     (k_c[g]),
         .q     (count[g]),
         .q_bar (count_bar[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap = wrap_q;
   assign tc   = en & (up ? is_max_c : is_zero_c);

endmodule
